// File: rtl/servo_pwm_gen_if.sv
// servo_pwm_gen_if -- control/observation bundle of the servo PWM stage.
//
// Signals:
//   en          run request; frames are generated while high
//   pos         8-bit target position from the position counter
//   pwm_out     servo PWM, high for width_us ticks at the start of each frame
//   frame_start one-clk pulse in the first cycle of every frame
//   pos_applied slew-limited position in use for the current frame
//
// Modports:
//   master  drives en/pos and observes the PWM side (position counter, bench)
//   slave   the PWM generator itself
interface servo_pwm_gen_if;
    logic       en;
    logic [7:0] pos;
    logic       pwm_out;
    logic       frame_start;
    logic [7:0] pos_applied;

    modport master (
        output en,
        output pos,
        input  pwm_out,
        input  frame_start,
        input  pos_applied
    );

    modport slave (
        input  en,
        input  pos,
        output pwm_out,
        output frame_start,
        output pos_applied
    );
endinterface

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen -- 50 Hz servo PWM generator for one arm joint.
//
// Samples the target position once per frame, slew-limits it by at most
// MAX_STEP per frame (0 = unlimited) and maps the result linearly onto a
// MIN_US .. MIN_US+SPAN_US high time. A frame, once started, always runs to
// completion, so pulses are never truncated by en falling.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-high
//   bus  servo_pwm_gen_if.slave: en, pos in; pwm_out, frame_start,
//        pos_applied out
//
// Parameters:
//   PRESCALE   clk cycles per 1 us tick (>= 1)
//   PERIOD_US  frame length in ticks
//   MIN_US     high time in ticks for pos_applied = 0
//   SPAN_US    high-time span in ticks (MIN_US + SPAN_US <= PERIOD_US)
//   MAX_STEP   max change of pos_applied per frame, 0 = unlimited
//   RESET_POS  reset value of pos_applied
module servo_pwm_gen #(
    parameter int PRESCALE  = 50,
    parameter int PERIOD_US = 20000,
    parameter int MIN_US    = 1000,
    parameter int SPAN_US   = 1000,
    parameter int MAX_STEP  = 0,
    parameter int RESET_POS = 128
) (
    input  logic            clk,
    input  logic            rst,
    servo_pwm_gen_if.slave  bus
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int US_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    // One extra bit so a width equal to PERIOD_US (permanently high) is
    // representable even when PERIOD_US is a power of two.
    localparam int WD_W = US_W + 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [US_W-1:0] US_LAST = US_W'(PERIOD_US - 1);
    localparam logic [7:0]      POS_RST = 8'(RESET_POS);

    // Elaboration-time parameter sanity.
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("servo_pwm_gen: PRESCALE must be >= 1");
    end
    if (MIN_US + SPAN_US > PERIOD_US) begin : g_bad_span
        $error("servo_pwm_gen: MIN_US + SPAN_US exceeds PERIOD_US");
    end
    if (MAX_STEP < 0) begin : g_bad_step
        $error("servo_pwm_gen: MAX_STEP must be >= 0");
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Move cur toward tgt by at most MAX_STEP. The result always lies
    // between cur and tgt, so no wrap can occur: when the step is taken the
    // distance exceeds MAX_STEP, hence cur +/- MAX_STEP stays inside 0..255.
    function automatic logic [7:0] step_pos(input logic [7:0] cur,
                                            input logic [7:0] tgt);
        logic [7:0] diff;
        logic [7:0] res;
        res = tgt;
        if (tgt >= cur) begin
            diff = tgt - cur;
            if (MAX_STEP != 0 && int'(diff) > MAX_STEP)
                res = cur + 8'(MAX_STEP);
        end else begin
            diff = cur - tgt;
            if (MAX_STEP != 0 && int'(diff) > MAX_STEP)
                res = cur - 8'(MAX_STEP);
        end
        return res;
    endfunction

    // High time in ticks: MIN_US + floor(p * SPAN_US / 256). The product is
    // kept at full width; pos = 255 therefore lands just short of the top.
    function automatic logic [WD_W-1:0] width_of(input logic [7:0] p);
        logic [39:0] prod;
        prod = 40'(p) * 40'(SPAN_US);
        return WD_W'(40'(MIN_US) + (prod >> 8));
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    state_t            state_nx;
    logic [PS_W-1:0]   prescaler;
    logic [US_W-1:0]   us_cnt;
    logic [WD_W-1:0]   width_us;
    logic [7:0]        pos_applied;
    logic              frame_start;
    logic              pwm;

    logic              tick;
    logic              frame_end;
    logic              fb;          // frame boundary taken on this edge
    logic [7:0]        pos_step;

    assign tick      = (state == RUN) && (prescaler == PS_LAST);
    assign frame_end = tick && (us_cnt == US_LAST);
    assign pos_step  = step_pos(pos_applied, bus.pos);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // ------------------------------------------------------------------
    // FSM: next state and frame-boundary decision
    // ------------------------------------------------------------------
    // en is only looked at on the IDLE->RUN edge and at the last tick of a
    // frame, so dropping en mid-frame lets the current frame finish.
    always_comb begin
        state_nx = state;
        fb       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_nx = RUN;
                    fb       = 1'b1;
                end
            end
            RUN: begin
                if (frame_end) begin
                    if (bus.en)
                        fb = 1'b1;
                    else
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Pure decode of registers (state, us_cnt, width_us); width_us only
    // changes at a frame boundary where us_cnt restarts at 0, so the
    // comparison never flips mid-pulse. Async reset clears state and thus
    // drops the pulse immediately.
    always_comb begin
        pwm = 1'b0;
        if (state == RUN)
            pwm = ({1'b0, us_cnt} < width_us);
    end

    // ------------------------------------------------------------------
    // Timebase: prescaler and microsecond counter
    // ------------------------------------------------------------------
    // Both counters sit at 0 in IDLE, so a new frame begins cleanly from
    // us_cnt = 0 on the IDLE->RUN edge. Leaving RUN always happens at the
    // wrap point, where both counters return to 0 anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            us_cnt    <= '0;
        end else if (state == RUN) begin
            prescaler <= tick ? '0 : prescaler + PS_W'(1);
            if (tick)
                us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + US_W'(1);
        end else begin
            prescaler <= '0;
            us_cnt    <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Per-frame position sample, slew limit and width
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_applied <= POS_RST;
            width_us    <= width_of(POS_RST);
            frame_start <= 1'b0;
        end else begin
            frame_start <= fb;
            if (fb) begin
                pos_applied <= pos_step;
                width_us    <= width_of(pos_step);
            end
        end
    end

    assign bus.pwm_out     = pwm;
    assign bus.frame_start = frame_start;
    assign bus.pos_applied = pos_applied;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen -- scoreboard bench for servo_pwm_gen.
//
// dut1: PRESCALE=2, PERIOD_US=40, MIN_US=10, SPAN_US=16, MAX_STEP=0
//       (frame = 80 clk). Checks pos_applied at every frame_start, the pulse
//       length of every frame, the frame spacing and that pwm stays low
//       outside pulses.
// dut2: same timebase with MAX_STEP=10, checks the per-frame slew sequence.
// Stimulus pushes the expected frame into a queue just before the frame
// boundary it targets; independent monitors pop at each frame_start.
module tb_servo_pwm_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    servo_pwm_gen_if b1 ();
    servo_pwm_gen_if b2 ();

    servo_pwm_gen #(
        .PRESCALE(2), .PERIOD_US(40), .MIN_US(10), .SPAN_US(16),
        .MAX_STEP(0), .RESET_POS(128)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    servo_pwm_gen #(
        .PRESCALE(2), .PERIOD_US(40), .MIN_US(10), .SPAN_US(16),
        .MAX_STEP(10), .RESET_POS(128)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(b2)
    );

    typedef struct {
        int pa;    // expected pos_applied
        int hi;    // expected pulse length in clk
        int gap;   // expected clk since previous frame_start, 0 = skip
    } exp_t;

    exp_t q1[$];
    int   q2[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Hand-computed pulse lengths in clk: 2 * (10 + floor(p*16/256)).
    function automatic int hi_of(input int p);
        case (p)
            0:       return 20;
            64:      return 28;
            128:     return 36;
            255:     return 50;
            default: return -1;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitor dut1
    // ------------------------------------------------------------------
    exp_t cur1;
    int   hi1     = 0;
    int   gap1    = 0;
    bit   act1    = 1'b0;
    bit   gap_ok1 = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            act1    = 1'b0;
            gap_ok1 = 1'b0;
        end else begin
            if (gap_ok1) gap1++;
            if (b1.frame_start) begin
                if (q1.size() == 0) begin
                    flag("dut1 unexpected frame_start");
                end else begin
                    cur1 = q1.pop_front();
                    check("dut1 pos_applied", int'(b1.pos_applied), cur1.pa);
                    if (cur1.gap != 0) check("dut1 frame_len", gap1, cur1.gap);
                    act1 = 1'b1;
                    hi1  = 0;
                end
                gap1    = 0;
                gap_ok1 = 1'b1;
            end
            if (act1) begin
                if (b1.pwm_out) begin
                    hi1++;
                end else begin
                    check("dut1 high_time", hi1, cur1.hi);
                    act1 = 1'b0;
                end
            end else begin
                check("dut1 pwm_low_outside_pulse", int'(b1.pwm_out), 0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor dut2
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst && b2.frame_start) begin
            if (q2.size() == 0)
                flag("dut2 unexpected frame_start");
            else
                check("dut2 pos_applied", int'(b2.pos_applied), q2.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all drives happen on the falling edge)
    // ------------------------------------------------------------------
    // Run one 80-clk frame on dut1, changing pos mid-frame; expect p next.
    task automatic frame1(input int p);
        repeat (40) @(negedge clk);
        b1.pos = 8'(p);
        repeat (40) @(negedge clk);
        q1.push_back('{pa: p, hi: hi_of(p), gap: 80});
    endtask

    // One frame with pos toggling 0<->255 every 7 clk; 11 flips, so the
    // value present at the next boundary is the opposite of start.
    task automatic toggle1(input int start);
        int p;
        p = start;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 0) begin
                b1.pos = 8'(p);
            end else if (i % 7 == 3) begin
                p = (p == 0) ? 255 : 0;
                b1.pos = 8'(p);
            end
        end
        q1.push_back('{pa: p, hi: hi_of(p), gap: 80});
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int up_seq[10] = '{138, 148, 158, 168, 178, 188, 198, 200, 200, 200};
    int dn_seq[10] = '{118, 108, 98, 88, 78, 68, 58, 48, 40, 40};

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        b1.en = 1'b0; b1.pos = 8'd0;
        b2.en = 1'b0; b2.pos = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst pwm_out", int'(b1.pwm_out), 0);
        check("rst frame_start", int'(b1.frame_start), 0);
        check("rst pos_applied dut1", int'(b1.pos_applied), 128);
        check("rst pos_applied dut2", int'(b2.pos_applied), 128);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle pos_applied", int'(b1.pos_applied), 128);

        // Slew limiting upward from 128 toward 200
        b2.en = 1'b1; b2.pos = 8'd200;
        q2.push_back(up_seq[0]);
        for (int k = 1; k < 10; k++) begin
            repeat (80) @(negedge clk);
            q2.push_back(up_seq[k]);
        end
        repeat (5) @(negedge clk);
        b2.en = 1'b0;
        pulse_rst();

        // Slew limiting downward from 128 toward 40
        b2.en = 1'b1; b2.pos = 8'd40;
        q2.push_back(dn_seq[0]);
        for (int k = 1; k < 10; k++) begin
            repeat (80) @(negedge clk);
            q2.push_back(dn_seq[k]);
        end
        repeat (5) @(negedge clk);
        b2.en = 1'b0;
        pulse_rst();
        repeat (5) @(negedge clk);

        // Basic frames, pos = 0 then 255 then 128
        b1.en = 1'b1; b1.pos = 8'd0;
        q1.push_back('{pa: 0, hi: 20, gap: 0});
        frame1(0);
        frame1(255);
        frame1(255);
        frame1(128);

        // pos glitching mid-frame: only the value at the boundary counts
        toggle1(0);
        toggle1(255);
        frame1(255);

        // en dropped 5 clk into a pos=255 frame: pulse completes, then IDLE
        repeat (5) @(negedge clk);
        b1.en = 1'b0; b1.pos = 8'd7;
        repeat (75) @(negedge clk);
        repeat (60) @(negedge clk);
        check("idle keeps pos_applied", int'(b1.pos_applied), 255);
        check("idle pwm_out", int'(b1.pwm_out), 0);

        // Restart: frame_start right after the enable edge
        b1.en = 1'b1; b1.pos = 8'd255;
        q1.push_back('{pa: 255, hi: 50, gap: 0});
        repeat (10) @(negedge clk);
        check("pwm high before rst", int'(b1.pwm_out), 1);

        // Async reset mid-pulse, no clock edge in between
        #2 rst = 1'b1;
        #1;
        check("async rst pwm_out", int'(b1.pwm_out), 0);
        check("async rst pos_applied", int'(b1.pos_applied), 128);
        b1.en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("post-rst idle pos_applied", int'(b1.pos_applied), 128);

        b1.en = 1'b1; b1.pos = 8'd64;
        q1.push_back('{pa: 64, hi: 28, gap: 0});
        frame1(64);
        repeat (5) @(negedge clk);
        b1.en = 1'b0;
        repeat (100) @(negedge clk);

        check("dut1 frames outstanding", q1.size(), 0);
        check("dut2 frames outstanding", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
Downstream stage of the 8-bit button-driven position counter. It consumes the counter's `pos` value and produces the 50 Hz servo PWM signal for one arm joint.
- `pos` is sampled once per PWM frame, passed through a per-frame slew limiter, and mapped linearly onto a MIN_US..MIN_US+SPAN_US high time.
- Output pulses are never truncated or shortened mid-frame.

Parameters:
PRESCALE, 50, clk cycles per 1 µs tick (50 MHz clk); legal range ≥1.
PERIOD_US, 20000, frame length in ticks.
MIN_US, 1000, high time in ticks for `pos_applied` = 0.
SPAN_US, 1000, high-time span in ticks; MIN_US+SPAN_US ≤ PERIOD_US is required.
MAX_STEP, 0, maximum change of `pos_applied` per frame; 0 = unlimited.
RESET_POS, 128, reset value of `pos_applied` (joint centre).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
en  input  1  run request; frames are generated while high.
pos  input  8  target position from the position counter.
pwm_out  output  1  servo PWM, high for width_us ticks at the start of each frame.
frame_start  output  1  one-clk pulse in the first cycle of every frame.
pos_applied  output  8  slew-limited position in use for the current frame.

Behaviour:
- Reset (async, rst=1): state=IDLE, prescaler=0, us_cnt=0, pwm_out=0, frame_start=0, pos_applied=RESET_POS, width_us=MIN_US+((RESET_POS*SPAN_US)>>8).
- Prescaler: counts 0..PRESCALE-1 in RUN only. `tick` = prescaler==PRESCALE-1. Held at 0 in IDLE.
- us_cnt: width $clog2(PERIOD_US). Increments on tick. Wraps PERIOD_US-1→0 on tick. Held at 0 in IDLE.
- Frame boundary event (FB): the clk edge of IDLE→RUN, or, in RUN, the edge where tick && us_cnt==PERIOD_US-1.
- At every FB edge, the registers are loaded:
  - pos_applied ← step(pos_applied, pos).
  - width_us ← MIN_US + ((step_result * SPAN_US) >> 8), using full-width unsigned product and integer truncation. The value is stable for the whole frame.
- step():
  - MAX_STEP=0 or |pos−pos_applied| ≤ MAX_STEP → pos.
  - Otherwise pos_applied ± MAX_STEP toward pos.
  - No overflow or wrap: the result always lies between the old value and pos.
- frame_start: registered. High for exactly the one cycle following each FB edge, i.e. the first cycle with us_cnt=0 of the new frame.
- pwm_out: combinational decode of registers only, glitch-free. pwm_out = (state==RUN) && (us_cnt < width_us).
  - High time = width_us*PRESCALE clk cycles.
  - Frame length = PERIOD_US*PRESCALE clk cycles.
- State machine:
  - IDLE: pwm_out=0. When en=1 → RUN; that edge is an FB.
  - RUN, at an FB candidate (tick && us_cnt==PERIOD_US-1):
    - en=1 → stay in RUN, FB taken.
    - en=0 → IDLE; no FB, so pos_applied and width_us are not updated and frame_start is not pulsed.
  - en falling mid-frame: the current frame completes in full, including any remaining high time. The block enters IDLE only at frame end.
- Latency:
  - `pos` is sampled only at FB edges. Changes between FBs are ignored, including glitches.
  - Worst-case reaction: 1 frame. With slew limiting: ceil(|Δ|/MAX_STEP) frames.
- Reset mid-frame: immediate return to reset values. pwm_out drops asynchronously. The partial pulse is accepted.
- Width extremes (default parameters):
  - pos=0 → 1000 µs.
  - pos=255 → 1996 µs (>>8 truncation; 2000 µs is never reached).

Test Plan:
Bench parameters: PRESCALE=2, PERIOD_US=40, MIN_US=10, SPAN_US=16, RESET_POS=128, MAX_STEP=0 (frame = 80 clk).
1. rst pulse, then en=1, pos=0 → frame_start at cycle 1 after the enable edge; pwm_out high 20 clk, low 60 clk; repeats every 80 clk; pos_applied=0.
2. pos=255 held → pwm_out high 50 clk per frame (width 25). pos=128 → high 36 clk (width 18).
3. pos toggled 0↔255 every 7 clk mid-frame → high time unchanged until the next frame_start; the new width equals the pos value present at the FB edge.
4. MAX_STEP=10, pos_applied=128, pos=200 → pos_applied per frame 138, 148, 158, 168, 178, 188, 198, 200, then constant. Same sequence with pos=40 descending: 118…48, 40.
5. en dropped at cycle 5 of a frame with pos=255 → full 50 clk high pulse completes; IDLE entered at the frame end; no further frame_start; pwm_out stays 0. en=1 again → frame_start on the next cycle.
6. rst asserted while pwm_out=1 → pwm_out=0 and pos_applied=128 without waiting for a clk edge; after release, IDLE until en.
